// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and the ALU evaluation function for alu_share_arbiter.
//   ALU_W / OP_W  : datapath and opcode widths
//   alu_op_e      : ALU opcode encoding (13..15 unused / illegal)
//   arb_state_e   : arbiter FSM states
//   alu_eval      : combinational ALU, returns 0 for illegal opcodes
//   op_illegal    : flags opcodes outside the defined set
package alu_share_arbiter_pkg;

   localparam int ALU_W = 16;
   localparam int OP_W  = 4;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_NOT  = 4'd5,
      OP_CLR  = 4'd6,
      OP_CMPE = 4'd7,
      OP_CMPG = 4'd8,
      OP_CMPL = 4'd9,
      OP_SHRA = 4'd10,
      OP_SHRL = 4'd11,
      OP_SHL  = 4'd12
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   function automatic logic op_illegal(input logic [OP_W-1:0] op);
      return (op > 4'd12);
   endfunction

   // Comparisons are unsigned; shifts take the full 16-bit B so any
   // shift amount >= 16 drains the word (sign-filled for SHRA).
   function automatic logic [ALU_W-1:0] alu_eval(input logic [OP_W-1:0]  op,
                                                 input logic [ALU_W-1:0] a,
                                                 input logic [ALU_W-1:0] b);
      logic [ALU_W:0]   sum;
      logic [ALU_W-1:0] res;
      sum = {1'b0, a} + {1'b0, b};
      res = '0;
      case (op)
         OP_ADD:  res = sum[ALU_W] ? '1 : sum[ALU_W-1:0];
         OP_SUB:  res = (a < b) ? '0 : (a - b);
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_XOR:  res = a ^ b;
         OP_NOT:  res = ~a;
         OP_CLR:  res = '0;
         OP_CMPE: res = {{(ALU_W-1){1'b0}}, (a == b)};
         OP_CMPG: res = {{(ALU_W-1){1'b0}}, (a > b)};
         OP_CMPL: res = {{(ALU_W-1){1'b0}}, (a < b)};
         OP_SHRA: res = $signed(a) >>> b;
         OP_SHRL: res = a >> b;
         OP_SHL:  res = a << b;
         default: res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester-side bus of the shared ALU arbiter.
//   req_valid/req_ready : per-requester request handshake
//   req_op/req_a/req_b  : flattened per-requester operands (requester i at slice i)
//   rsp_valid/rsp_ready : per-requester response handshake (rsp_valid one-hot)
//   rsp_data/rsp_err    : shared result bus and illegal-opcode flag
//   busy                : arbiter is executing or holding a response
// master = requesters, slave = arbiter.
interface alu_share_arbiter_if
   import alu_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) ();

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*OP_W-1:0]  req_op;
   logic [NUM_REQ*ALU_W-1:0] req_a;
   logic [NUM_REQ*ALU_W-1:0] req_b;
   logic [NUM_REQ-1:0]       rsp_valid;
   logic [NUM_REQ-1:0]       rsp_ready;
   logic [ALU_W-1:0]         rsp_data;
   logic                     rsp_err;
   logic                     busy;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err, busy
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err, busy
   );

endinterface

// File: rtl/alu_share_arbiter_rr_arbiter_comb.sv
// Combinational round-robin grant.
//   req     : request vector
//   rr_ptr  : last granted index; search starts at rr_ptr+1 (mod NUM_REQ)
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : binary index of the grant
//   gnt_any : some request was granted
module rr_arbiter_comb #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_any
);

   int idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx = (int'(rr_ptr) + off) % NUM_REQ;
         if (!gnt_any && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = IDX_W'(idx);
            gnt_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one 16-bit ALU between NUM_REQ requesters with round-robin
// arbitration, registered operand capture and a registered result.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_share_arbiter_if.slave (request/response handshakes)
// Build option: define ALU_ARB_ERR_EN to flag opcodes 13..15 on rsp_err;
// otherwise rsp_err is tied low and illegal ops just return 0.
//
// state   | meaning
// ST_IDLE | waiting for a request; req_ready shows the round-robin winner
// ST_EXEC | ALU evaluates latched operands, result registered
// ST_RESP | rsp_valid to the owner, held until its rsp_ready
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_share_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_e         state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q;
   logic [IDX_W-1:0]   idx_q;
   logic [OP_W-1:0]    op_q;
   logic [ALU_W-1:0]   a_q, b_q;
   logic [ALU_W-1:0]   data_q;
   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_any;
   logic               accept;
   logic [NUM_REQ-1:0] req_ready;
   logic [NUM_REQ-1:0] rsp_valid;
   logic               busy;

   rr_arbiter_comb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req     (bus.req_valid),
      .rr_ptr  (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // The grant is drawn only from asserted req_valid bits, so any grant in
   // IDLE is an accepted handshake.
   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      rsp_valid = '0;
      busy      = 1'b0;
      accept    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = gnt;
            if (gnt_any) begin
               accept  = 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            busy    = 1'b1;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            busy             = 1'b1;
            rsp_valid[idx_q] = 1'b1;
            if (bus.rsp_ready[idx_q]) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= IDX_W'(NUM_REQ - 1);
         idx_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         data_q   <= '0;
      end else begin
         if (accept) begin
            rr_ptr_q <= gnt_idx;
            idx_q    <= gnt_idx;
            op_q     <= bus.req_op[int'(gnt_idx)*OP_W +: OP_W];
            a_q      <= bus.req_a[int'(gnt_idx)*ALU_W +: ALU_W];
            b_q      <= bus.req_b[int'(gnt_idx)*ALU_W +: ALU_W];
         end
         if (state_q == ST_EXEC) data_q <= alu_eval(op_q, a_q, b_q);
      end
   end

`ifdef ALU_ARB_ERR_EN
   logic err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  err_q <= 1'b0;
      else if (state_q == ST_EXEC) err_q <= op_illegal(op_q);
   end

   assign bus.rsp_err = err_q;
`else
   assign bus.rsp_err = 1'b0;
`endif

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_data  = data_q;
   assign bus.busy      = busy;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
   import alu_share_arbiter_pkg::*;

   localparam int N = 4;
`ifdef ALU_ARB_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   typedef struct {
      int          idx;
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp_data;
      logic        exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   alu_share_arbiter_if #(.NUM_REQ(N)) bus ();

   alu_share_arbiter #(.NUM_REQ(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add_vec(input int idx, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] d, input logic e);
      vec_t v;
      v.idx = idx; v.op = op; v.a = a; v.b = b; v.exp_data = d; v.exp_err = e;
      vecs.push_back(v);
   endtask

   // Single request from one requester with rsp_ready high; bounded waits.
   task automatic run_op(input int idx, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, output logic [15:0] data,
                         output logic err, output bit ok);
      int n;
      ok = 1'b1; data = '0; err = 1'b0;
      @(negedge clk);
      bus.req_op[idx*4 +: 4]   = op;
      bus.req_a[idx*16 +: 16]  = a;
      bus.req_b[idx*16 +: 16]  = b;
      bus.rsp_ready[idx]       = 1'b1;
      bus.req_valid[idx]       = 1'b1;
      #1;
      n = 0;
      while (!bus.req_ready[idx] && n < 20) begin
         @(negedge clk); #1; n++;
      end
      if (!bus.req_ready[idx]) ok = 1'b0;
      @(posedge clk); #1;
      bus.req_valid[idx] = 1'b0;
      n = 0;
      while (!bus.rsp_valid[idx] && n < 20) begin
         @(negedge clk); n++;
      end
      if (!bus.rsp_valid[idx]) ok = 1'b0;
      data = bus.rsp_data;
      err  = bus.rsp_err;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d;
      logic        e;
      bit          ok;
      int          n, cyc, last;
      logic        seen;

      bus.req_valid = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = '0;

      add_vec(1, 4'd0,  16'hFFF0, 16'h0020, 16'hFFFF, 1'b0);
      add_vec(2, 4'd1,  16'h0005, 16'h0009, 16'h0000, 1'b0);
      add_vec(3, 4'd10, 16'h8000, 16'h0004, 16'hF800, 1'b0);
      add_vec(0, 4'd0,  16'h0003, 16'h0004, 16'h0007, 1'b0);
      add_vec(1, 4'd1,  16'h0009, 16'h0005, 16'h0004, 1'b0);
      add_vec(2, 4'd2,  16'hF0F0, 16'hFF00, 16'hF000, 1'b0);
      add_vec(3, 4'd3,  16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0);
      add_vec(0, 4'd4,  16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b0);
      add_vec(1, 4'd5,  16'h1234, 16'h0000, 16'hEDCB, 1'b0);
      add_vec(2, 4'd6,  16'h1234, 16'h5678, 16'h0000, 1'b0);
      add_vec(3, 4'd7,  16'h0055, 16'h0055, 16'h0001, 1'b0);
      add_vec(0, 4'd8,  16'h0005, 16'h0009, 16'h0000, 1'b0);
      add_vec(1, 4'd8,  16'h0009, 16'h0005, 16'h0001, 1'b0);
      add_vec(2, 4'd9,  16'h0005, 16'h0009, 16'h0001, 1'b0);
      add_vec(3, 4'd11, 16'h8000, 16'h0004, 16'h0800, 1'b0);
      add_vec(0, 4'd12, 16'h0001, 16'h000F, 16'h8000, 1'b0);
      add_vec(1, 4'd12, 16'h0001, 16'h0010, 16'h0000, 1'b0);
      add_vec(2, 4'd10, 16'h8000, 16'h0100, 16'hFFFF, 1'b0);
      add_vec(3, 4'd14, 16'h1234, 16'h5678, 16'h0000, ERR_EN);
      add_vec(0, 4'd13, 16'hFFFF, 16'hFFFF, 16'h0000, ERR_EN);
      add_vec(1, 4'd15, 16'h0001, 16'h0001, 16'h0000, ERR_EN);

      // reset state
      repeat (2) @(negedge clk);
      check("rst_req_ready", bus.req_ready, 4'h0);
      check("rst_rsp_valid", bus.rsp_valid, 4'h0);
      check("rst_rsp_data",  bus.rsp_data, 16'h0000);
      check("rst_rsp_err",   bus.rsp_err, 1'b0);
      check("rst_busy",      bus.busy, 1'b0);
      rst_n = 1'b1;

      // first op: same-cycle ready, response after two edges
      @(negedge clk);
      bus.req_op[3:0] = 4'd0; bus.req_a[15:0] = 16'h0003; bus.req_b[15:0] = 16'h0004;
      bus.rsp_ready = 4'b0001;
      bus.req_valid = 4'b0001;
      #1;
      check("t1_req_ready", bus.req_ready, 4'b0001);
      check("t1_busy_idle", bus.busy, 1'b0);
      @(posedge clk); #1;
      bus.req_valid = 4'b0000;
      check("t1_exec_busy",  bus.busy, 1'b1);
      check("t1_exec_ready", bus.req_ready, 4'b0000);
      check("t1_exec_rspv",  bus.rsp_valid, 4'b0000);
      @(posedge clk); #1;
      check("t1_rsp_valid", bus.rsp_valid, 4'b0001);
      check("t1_rsp_data",  bus.rsp_data, 16'h0007);
      check("t1_rsp_err",   bus.rsp_err, 1'b0);
      @(posedge clk); #1;
      check("t1_done_rspv", bus.rsp_valid, 4'b0000);
      check("t1_done_busy", bus.busy, 1'b0);

      // round-robin with all requesting; restart from reset pointer
      @(negedge clk);
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         bus.req_op[i*4 +: 4]  = 4'd0;
         bus.req_a[i*16 +: 16] = 16'(i * 16);
         bus.req_b[i*16 +: 16] = 16'h0001;
      end
      bus.rsp_ready = 4'hF;
      bus.req_valid = 4'hF;
      cyc = 0; last = 0;
      for (int k = 0; k < 5; k++) begin
         logic [3:0] exp_g;
         exp_g = 4'(1 << (k % N));
         n = 0;
         #1;
         while (bus.req_ready == 4'h0 && n < 10) begin
            @(negedge clk); #1; cyc++; n++;
         end
         check("rr_order", bus.req_ready, exp_g);
         if (k > 0) check("rr_gap", cyc - last, 3);
         last = cyc;
         @(negedge clk); cyc++;
         #1;
         if (k < 4) begin
            @(negedge clk); cyc++;
            check("rr_rsp_data", bus.rsp_data, 16'((k % N) * 16 + 1));
         end
      end
      bus.req_valid = 4'h0;
      repeat (3) @(negedge clk);
      check("rr_drain_busy", bus.busy, 1'b0);

      // table-driven ALU vectors (single requester each)
      for (int i = 0; i < vecs.size(); i++) begin
         run_op(vecs[i].idx, vecs[i].op, vecs[i].a, vecs[i].b, d, e, ok);
         check($sformatf("vec%0d_handshake", i), ok, 1'b1);
         check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
         check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
      end

      // response back-pressure on requester 2; req0 waits meanwhile
      @(negedge clk);
      bus.req_op[8 +: 4] = 4'd0; bus.req_a[32 +: 16] = 16'h1000; bus.req_b[32 +: 16] = 16'h0234;
      bus.req_op[0 +: 4] = 4'd0; bus.req_a[0 +: 16] = 16'h0001; bus.req_b[0 +: 16] = 16'h0001;
      bus.rsp_ready = 4'b1011;
      bus.req_valid = 4'b0100;
      #1;
      n = 0;
      while (!bus.req_ready[2] && n < 10) begin
         @(negedge clk); #1; n++;
      end
      check("bp_grant", bus.req_ready, 4'b0100);
      @(posedge clk); #1;
      bus.req_valid = 4'b0001;
      n = 0;
      while (!bus.rsp_valid[2] && n < 10) begin
         @(negedge clk); n++;
      end
      for (int c = 0; c < 5; c++) begin
         check("bp_rsp_valid", bus.rsp_valid, 4'b0100);
         check("bp_rsp_data",  bus.rsp_data, 16'h1234);
         check("bp_req_ready", bus.req_ready, 4'b0000);
         check("bp_busy",      bus.busy, 1'b1);
         @(negedge clk);
      end
      bus.rsp_ready = 4'b1111;
      @(posedge clk); #1;
      check("bp_released", bus.rsp_valid, 4'b0000);
      check("bp_next_grant", bus.req_ready, 4'b0001);
      @(posedge clk); #1;
      bus.req_valid = 4'b0000;
      repeat (3) @(negedge clk);
      check("bp_req0_data", bus.rsp_data, 16'h0002);

      // reset during EXEC: no response, pointer back to reset value
      @(negedge clk);
      bus.req_valid = 4'b0100;
      #1;
      n = 0;
      while (!bus.req_ready[2] && n < 10) begin
         @(negedge clk); #1; n++;
      end
      @(posedge clk); #1;
      bus.req_valid = 4'b0000;
      check("mr_exec_busy", bus.busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("mr_busy",      bus.busy, 1'b0);
      check("mr_rsp_valid", bus.rsp_valid, 4'b0000);
      check("mr_rsp_data",  bus.rsp_data, 16'h0000);
      check("mr_req_ready", bus.req_ready, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus.rsp_valid != 4'b0000) seen = 1'b1;
      end
      check("mr_no_response", seen, 1'b0);
      bus.req_valid = 4'hF;
      #1;
      check("mr_next_grant", bus.req_ready, 4'b0001);
      @(posedge clk); #1;
      bus.req_valid = 4'h0;
      repeat (4) @(negedge clk);
      check("mr_final_busy", bus.busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
